inv_sub_bytes_seq: RTL

//  Iterative AES InvSubBytes engine. Takes a 128-bit state, applies the inverse S-box to all
//  16 bytes over 16/LANES cycles, and returns the result. The decrypt datapath uses it as the

---
 rtl/aes_pkg.sv | 53 +++++
 rtl/inv_sbox.sv | 23 ++
 rtl/inv_sub_bytes_seq.sv | 119 +++++++++++
 3 files changed

// File: rtl/aes_pkg.sv
// Shared AES byte/state types, S-box tables and the InvSubBytes engine state encoding.
package aes_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [127:0] state_t;

    localparam int NUM_BYTES = 16;

    typedef enum logic [1:0] {
        IBS_IDLE = 2'd0,
        IBS_RUN  = 2'd1,
        IBS_DONE = 2'd2
    } ibs_state_e;

    localparam byte_t SBOX_TABLE [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    localparam byte_t INV_SBOX_TABLE [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

endpackage

// File: rtl/inv_sbox.sv
// Single-byte combinational inverse S-box lookup.
// With INV_SUB_BYTES_FWD_EN defined, a fwd select picks the forward table instead.
module inv_sbox
    import aes_pkg::*;
(
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic       fwd,
`endif
    input  logic [7:0] din,
    output logic [7:0] dout
);

`ifdef INV_SUB_BYTES_FWD_EN
    always_comb begin
        dout = fwd ? SBOX_TABLE[din] : INV_SBOX_TABLE[din];
    end
`else
    always_comb begin
        dout = INV_SBOX_TABLE[din];
    end
`endif

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// Iterative AES InvSubBytes engine: LANES shared S-boxes walk the 16 state bytes in 16/LANES steps.
// Optional INV_SUB_BYTES_FWD_EN adds an Encrypt input selecting the forward S-box.
//
//   state    | meaning
//   IBS_IDLE | in_ready=1, waiting for a block
//   IBS_RUN  | substituting LANES bytes per cycle
//   IBS_DONE | out_valid=1, holding result until out_ready
module inv_sub_bytes_seq
    import aes_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] Indata,
`ifdef INV_SUB_BYTES_FWD_EN
    input  logic         Encrypt,
`endif
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] data
);

    localparam int STEPS  = NUM_BYTES / LANES;
    localparam int STEP_W = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(STEPS - 1);

    generate
        if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
            $error("inv_sub_bytes_seq: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    ibs_state_e                  state_q, state_d;
    logic [STEP_W-1:0]           step_q;
    byte_t [NUM_BYTES-1:0]       src_q;
    byte_t [NUM_BYTES-1:0]       data_q;
    logic  [3:0]                 lane_idx [LANES];
    byte_t                       lane_out [LANES];
`ifdef INV_SUB_BYTES_FWD_EN
    logic                        enc_q;
`endif

    // Lane l handles byte step*LANES+l, so each step covers a contiguous byte group.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        assign lane_idx[l] = 4'(int'(step_q) * LANES + l);

        inv_sbox u_sbox (
`ifdef INV_SUB_BYTES_FWD_EN
            .fwd  (enc_q),
`endif
            .din  (src_q[lane_idx[l]]),
            .dout (lane_out[l])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IBS_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IBS_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_d = IBS_RUN;
            end
            IBS_RUN: begin
                if (step_q == LAST_STEP) state_d = IBS_DONE;
            end
            IBS_DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IBS_IDLE;
            end
            default: state_d = IBS_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_q <= '0;
            src_q  <= '0;
            data_q <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
            enc_q  <= 1'b0;
`endif
        end else begin
            case (state_q)
                IBS_IDLE: begin
                    if (in_valid) begin
                        src_q  <= Indata;
                        step_q <= '0;
`ifdef INV_SUB_BYTES_FWD_EN
                        enc_q  <= Encrypt;
`endif
                    end
                end
                IBS_RUN: begin
                    for (int l = 0; l < LANES; l++) begin
                        data_q[lane_idx[l]] <= lane_out[l];
                    end
                    step_q <= (step_q == LAST_STEP) ? '0 : step_q + STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign data = data_q;

endmodule
